// File: rtl/video_timing_gen.sv
// Raster timing and framebuffer word-address generator for the video shifter.
// Define VIDEO_ALT_PAGE_EN to add the page_sel input and the alternate screen page.
module video_timing_gen #(
    parameter int                H_VISIBLE  = 128,
    parameter int                H_TOTAL    = 168,
    parameter int                H_SYNC_ST  = 131,
    parameter int                H_SYNC_END = 147,
    parameter int                V_VIS_ST   = 42,
    parameter int                V_VIS_END  = 725,
    parameter int                V_TOTAL    = 806,
    parameter int                V_SYNC_ST  = 771,
    parameter int                V_SYNC_END = 776,
    parameter int                PIX_LAT    = 1,
    parameter int                HS_POL     = 0,
    parameter int                VS_POL     = 0,
    parameter int                V_DOUBLE   = 1,
    parameter int                ADDR_W     = 22,
    parameter logic [ADDR_W-1:0] FB_BASE    = 22'h3FA700,
    parameter logic [ADDR_W-1:0] FB_ALT_OFS = 22'h008000,
    parameter int                LINE_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk_en,
    input  logic [1:0]        bus_cycle,
`ifdef VIDEO_ALT_PAGE_EN
    input  logic              page_sel,
`endif
    output logic [ADDR_W-1:0] video_addr,
    output logic              hsync,
    output logic              vsync,
    output logic              hblank_n,
    output logic              vblank_n,
    output logic              load_pixels,
    output logic              vblank_irq
);

    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);

    localparam logic [XW-1:0] X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_VIS      = XW'(H_VISIBLE);
    localparam logic [XW-1:0] HS_FIRST   = XW'(H_SYNC_ST + PIX_LAT);
    localparam logic [XW-1:0] HS_LAST    = XW'(H_SYNC_END + PIX_LAT);
    localparam logic [YW-1:0] Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_VIS_ST   = YW'(V_VIS_ST);
    localparam logic [YW-1:0] Y_VIS_END  = YW'(V_VIS_END);
    localparam logic [YW-1:0] Y_SYNC_ST  = YW'(V_SYNC_ST);
    localparam logic [YW-1:0] Y_SYNC_END = YW'(V_SYNC_END);
    localparam logic [ADDR_W-1:0] LINE_INC = ADDR_W'(LINE_BYTES);
    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    if ((H_SYNC_END + PIX_LAT >= H_TOTAL) || (V_VIS_END >= V_TOTAL)) begin : g_param_check
        $error("video_timing_gen: sync window or visible end exceeds total");
    end

    logic [XW-1:0]     xpos;
    logic [YW-1:0]     ypos;
    logic [YW-1:0]     ypos_next;
    logic [ADDR_W-1:0] row_addr;
    logic [ADDR_W-1:0] page_base;
    logic              dbl;
    logic              endline;
    logic              phase_hold;
    logic              line_vis;

    assign endline    = (xpos == X_LAST);
    assign phase_hold = (xpos == '0) && (bus_cycle != 2'd0);
    assign ypos_next  = (ypos == Y_LAST) ? '0 : ypos + YW'(1);
    assign line_vis   = (ypos >= Y_VIS_ST) && (ypos <= Y_VIS_END);

`ifdef VIDEO_ALT_PAGE_EN
    logic page;

    // Page is latched only at vblank start so a frame is never split across pages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            page <= 1'b0;
        end else if (clk_en && endline && (ypos == Y_VIS_END)) begin
            page <= page_sel;
        end
    end

    assign page_base = page ? (FB_BASE - FB_ALT_OFS) : FB_BASE;
`else
    assign page_base = FB_BASE;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xpos       <= '0;
            ypos       <= '0;
            row_addr   <= FB_BASE;
            dbl        <= 1'b0;
            hsync      <= ~HS_ACT;
            vsync      <= ~VS_ACT;
            vblank_irq <= 1'b0;
        end else if (clk_en) begin
            hsync      <= ((xpos >= HS_FIRST) && (xpos <= HS_LAST)) ? HS_ACT : ~HS_ACT;
            vsync      <= ((ypos >= Y_SYNC_ST) && (ypos <= Y_SYNC_END)) ? VS_ACT : ~VS_ACT;
            vblank_irq <= endline && (ypos == Y_VIS_END);
            if (endline) begin
                xpos <= '0;
                ypos <= ypos_next;
                // Row address restarts at the page base just before the first visible line.
                if (ypos_next == Y_VIS_ST) begin
                    row_addr <= page_base;
                    dbl      <= 1'b0;
                end else if (line_vis) begin
                    if (V_DOUBLE != 0) begin
                        dbl <= ~dbl;
                        if (dbl) begin
                            row_addr <= row_addr + LINE_INC;
                        end
                    end else begin
                        row_addr <= row_addr + LINE_INC;
                    end
                end
            end else if (!phase_hold) begin
                xpos <= xpos + XW'(1);
            end
        end
    end

    // One 16-bit word (two bytes) is fetched per four ticks.
    assign video_addr  = row_addr + {{(ADDR_W - XW + 1){1'b0}}, xpos[XW-1:2], 1'b0};
    assign hblank_n    = (xpos < X_VIS);
    assign vblank_n    = line_vis;
    assign load_pixels = hblank_n && vblank_n && (bus_cycle == 2'd0);

endmodule
